// File: rtl/jamia_lsu_pkg.sv
// jamia_lsu_pkg
//   Shared constants for the load/store unit:
//   - access-size codes (funct3[1:0])
//   - FSM state encoding
//   - store-lane helpers (byte-lane write mask and lane-replicated write data)
package jamia_lsu_pkg;

   localparam logic [1:0] LS_BYTE = 2'b00;
   localparam logic [1:0] LS_HALF = 2'b01;
   localparam logic [1:0] LS_WORD = 2'b10;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;

   // Size code 2'b11 is handled as a full word.
   function automatic logic [3:0] store_mask(input logic [1:0] size, input logic [1:0] offset);
      logic [3:0] mask;
      case (size)
         LS_BYTE: mask = 4'b0001 << offset;
         LS_HALF: mask = offset[1] ? 4'b1100 : 4'b0011;
         default: mask = 4'b1111;
      endcase
      return mask;
   endfunction

   function automatic logic [31:0] store_wdata(input logic [1:0] size, input logic [31:0] data);
      logic [31:0] wdata;
      case (size)
         LS_BYTE: wdata = {4{data[7:0]}};
         LS_HALF: wdata = {2{data[15:0]}};
         default: wdata = data;
      endcase
      return wdata;
   endfunction

endpackage

// File: rtl/lsu_load_formatter.sv
// lsu_load_formatter
//   Combinational load-data formatter: extracts the addressed byte or halfword
//   from a bus word and sign- or zero-extends it to 32 bits.
//   rdata        in   32  raw bus read data
//   offset       in   2   address bits [1:0]
//   size         in   2   00 byte, 01 half, 10/11 word
//   is_unsigned  in   1   zero-extend instead of sign-extend
//   data         out  32  formatted result
module lsu_load_formatter
   import jamia_lsu_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [1:0]  size,
   input  logic        is_unsigned,
   output logic [31:0] data
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = rdata[{offset, 3'b000} +: 8];
      half_sel = rdata[{offset[1], 4'b0000} +: 16];
      case (size)
         LS_BYTE: data = {{24{byte_sel[7] & ~is_unsigned}}, byte_sel};
         LS_HALF: data = {{16{half_sel[15] & ~is_unsigned}}, half_sel};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit
//   Memory half of a decoded load/store. Issues one req/ack bus transaction per
//   aligned access, stalls the core while it is open, and returns formatted load
//   data with a one-cycle done pulse (or a bus_fault pulse on err/timeout).
//   clk_in, rst_in            clock, asynchronous active-high reset
//   lsu_valid_in, load_req_in, mem_wr_req_in, misaligned_in,
//   load_size_in, load_unsigned_in, iadder_in, rs2_in
//                             decoded request from execute
//   dbus_req/we/addr/wdata/wmask_out, dbus_ack_in, dbus_err_in, dbus_rdata_in
//                             data-memory bus
//   lsu_stall_out             hold fetch/decode/execute
//   lsu_done_out, bus_fault_out  one-cycle completion pulses
//   load_data_out             formatted load result, held until next good load
module load_store_unit
   import jamia_lsu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        lsu_valid_in,
   input  logic        load_req_in,
   input  logic        mem_wr_req_in,
   input  logic        misaligned_in,
   input  logic [1:0]  load_size_in,
   input  logic        load_unsigned_in,
   input  logic [31:0] iadder_in,
   input  logic [31:0] rs2_in,
   output logic        dbus_req_out,
   output logic        dbus_we_out,
   output logic [31:0] dbus_addr_out,
   output logic [31:0] dbus_wdata_out,
   output logic [3:0]  dbus_wmask_out,
   input  logic        dbus_ack_in,
   input  logic        dbus_err_in,
   input  logic [31:0] dbus_rdata_in,
   output logic        lsu_stall_out,
   output logic        lsu_done_out,
   output logic [31:0] load_data_out,
   output logic        bus_fault_out
);

   logic [0:0]  state;
   logic [1:0]  size_q;
   logic [1:0]  offset_q;
   logic        unsigned_q;
   logic [15:0] busy_cnt;
   logic        issue;
   logic        expired;
   logic [31:0] fmt_data;

   assign issue   = (state == ST_IDLE) & lsu_valid_in & (load_req_in | mem_wr_req_in) & ~misaligned_in;
   // busy_cnt is 0 in the first BUSY cycle, so the last allowed cycle is TIMEOUT-1.
   assign expired = (busy_cnt == 16'(TIMEOUT_CYCLES - 1));
   assign lsu_stall_out = issue | (state == ST_BUSY);

   lsu_load_formatter u_fmt (
      .rdata       (dbus_rdata_in),
      .offset      (offset_q),
      .size        (size_q),
      .is_unsigned (unsigned_q),
      .data        (fmt_data)
   );

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state          <= ST_IDLE;
         dbus_req_out   <= 1'b0;
         dbus_we_out    <= 1'b0;
         dbus_addr_out  <= '0;
         dbus_wdata_out <= '0;
         dbus_wmask_out <= '0;
         lsu_done_out   <= 1'b0;
         bus_fault_out  <= 1'b0;
         load_data_out  <= '0;
         size_q         <= '0;
         offset_q       <= '0;
         unsigned_q     <= 1'b0;
         busy_cnt       <= '0;
      end else begin
         lsu_done_out  <= 1'b0;
         bus_fault_out <= 1'b0;
         if (state == ST_IDLE) begin
            if (issue) begin
               state          <= ST_BUSY;
               dbus_req_out   <= 1'b1;
               dbus_we_out    <= ~load_req_in;
               dbus_addr_out  <= {iadder_in[31:2], 2'b00};
               dbus_wdata_out <= load_req_in ? '0 : store_wdata(load_size_in, rs2_in);
               dbus_wmask_out <= load_req_in ? '0 : store_mask(load_size_in, iadder_in[1:0]);
               size_q         <= load_size_in;
               offset_q       <= iadder_in[1:0];
               unsigned_q     <= load_unsigned_in;
               busy_cnt       <= '0;
            end
         end else begin
            if (dbus_err_in | dbus_ack_in | expired) begin
               state        <= ST_IDLE;
               dbus_req_out <= 1'b0;
               busy_cnt     <= '0;
               // err beats ack; ack beats a simultaneous timeout.
               if (dbus_err_in) begin
                  bus_fault_out <= 1'b1;
               end else if (dbus_ack_in) begin
                  lsu_done_out <= 1'b1;
                  if (!dbus_we_out) load_data_out <= fmt_data;
               end else begin
                  bus_fault_out <= 1'b1;
               end
            end else begin
               busy_cnt <= busy_cnt + 16'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   localparam int unsigned T = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        lsu_valid, load_req, mem_wr_req, misaligned;
   logic [1:0]  load_size;
   logic        load_unsigned;
   logic [31:0] iadder, rs2;
   logic        dbus_req, dbus_we;
   logic [31:0] dbus_addr, dbus_wdata;
   logic [3:0]  dbus_wmask;
   logic        dbus_ack, dbus_err;
   logic [31:0] dbus_rdata;
   logic        lsu_stall, lsu_done, bus_fault;
   logic [31:0] load_data;

   int unsigned tests = 0;
   int unsigned fails = 0;
   logic [31:0] exp_load = '0;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
      .clk_in           (clk),
      .rst_in           (rst),
      .lsu_valid_in     (lsu_valid),
      .load_req_in      (load_req),
      .mem_wr_req_in    (mem_wr_req),
      .misaligned_in    (misaligned),
      .load_size_in     (load_size),
      .load_unsigned_in (load_unsigned),
      .iadder_in        (iadder),
      .rs2_in           (rs2),
      .dbus_req_out     (dbus_req),
      .dbus_we_out      (dbus_we),
      .dbus_addr_out    (dbus_addr),
      .dbus_wdata_out   (dbus_wdata),
      .dbus_wmask_out   (dbus_wmask),
      .dbus_ack_in      (dbus_ack),
      .dbus_err_in      (dbus_err),
      .dbus_rdata_in    (dbus_rdata),
      .lsu_stall_out    (lsu_stall),
      .lsu_done_out     (lsu_done),
      .load_data_out    (load_data),
      .bus_fault_out    (bus_fault)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference formatting from plain arithmetic on the address offset.
   function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int unsigned a,
                                            input int unsigned sz, input bit uns);
      logic [31:0] v;
      if (sz == 0) begin
         v = (rdata >> (8 * a)) & 32'hFF;
         if (!uns && v[7]) v = v | 32'hFFFF_FF00;
      end else if (sz == 1) begin
         v = (rdata >> (16 * (a / 2))) & 32'hFFFF;
         if (!uns && v[15]) v = v | 32'hFFFF_0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   function automatic logic [31:0] ref_mask(input int unsigned a, input int unsigned sz);
      if (sz == 0) return 32'(1 << a);
      if (sz == 1) return 32'(3 << ((a / 2) * 2));
      return 32'hF;
   endfunction

   function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int unsigned sz);
      if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
      if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
      return d;
   endfunction

   // Runs one request starting #1 after a rising edge; slave responds in BUSY cycle 'delay'.
   task automatic txn(input bit ld, input bit mis, input logic [1:0] sz, input bit uns,
                      input logic [31:0] addr, input logic [31:0] data, input logic [31:0] rdata,
                      input int unsigned delay, input bit ack, input bit err);
      bit          exit_resp;
      bit          done_exp;
      int unsigned busy;
      int unsigned stalls;
      exit_resp = (ack || err) && (delay <= T);
      busy      = exit_resp ? delay : T;
      done_exp  = exit_resp && ack && !err;
      stalls    = 0;

      lsu_valid = 1'b1; load_req = ld; mem_wr_req = !ld; misaligned = mis;
      load_size = sz; load_unsigned = uns; iadder = addr; rs2 = data; dbus_rdata = rdata;
      #1;
      check("stall_issue", 32'(lsu_stall), 32'(!mis));
      if (lsu_stall) stalls++;
      @(posedge clk); #1;
      lsu_valid = 1'b0; load_req = 1'b0; mem_wr_req = 1'b0; misaligned = 1'b0;

      if (mis) begin
         check("mis_req", 32'(dbus_req), 0);
         check("mis_stall", 32'(lsu_stall), 0);
         check("mis_pulses", {30'b0, lsu_done, bus_fault}, 0);
         return;
      end

      check("addr", dbus_addr, addr & 32'hFFFF_FFFC);
      check("we", 32'(dbus_we), 32'(!ld));
      check("wmask", 32'(dbus_wmask), ld ? 32'h0 : ref_mask(int'(addr[1:0]), int'(sz)));
      if (!ld) check("wdata", dbus_wdata, ref_wdata(data, int'(sz)));
      check("pulses_busy", {30'b0, lsu_done, bus_fault}, 0);

      for (int unsigned c = 1; c <= busy; c++) begin
         check("req_busy", 32'(dbus_req), 1);
         if (c == delay) begin dbus_ack = ack; dbus_err = err; end
         #1;
         if (lsu_stall) stalls++;
         @(posedge clk); #1;
         dbus_ack = 1'b0; dbus_err = 1'b0;
      end

      if (done_exp && ld) exp_load = ref_load(rdata, int'(addr[1:0]), int'(sz), uns);
      check("req_end", 32'(dbus_req), 0);
      check("done", 32'(lsu_done), 32'(done_exp));
      check("fault", 32'(bus_fault), 32'(!done_exp));
      check("load_data", load_data, exp_load);
      check("stall_end", 32'(lsu_stall), 0);
      check("stall_cycles", stalls, 1 + busy);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; lsu_valid = 1'b0; load_req = 1'b0; mem_wr_req = 1'b0; misaligned = 1'b0;
      load_size = '0; load_unsigned = 1'b0; iadder = '0; rs2 = '0;
      dbus_ack = 1'b0; dbus_err = 1'b0; dbus_rdata = '0;
      @(posedge clk); @(posedge clk); #1;
      check("rst_outs", {26'b0, dbus_req, dbus_we, lsu_stall, lsu_done, bus_fault, |dbus_wmask}, 0);
      check("rst_addr", dbus_addr, 0);
      check("rst_load", load_data, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Directed cases
      txn(1'b0, 1'b0, 2'b00, 1'b0, 32'h1003, 32'hAABBCCDD, 32'h0, 3, 1'b1, 1'b0); // SB
      txn(1'b1, 1'b0, 2'b01, 1'b0, 32'h2002, 32'h0, 32'h8001_1234, 1, 1'b1, 1'b0); // LH
      check("lh", load_data, 32'hFFFF8001);
      txn(1'b1, 1'b0, 2'b01, 1'b1, 32'h2002, 32'h0, 32'h8001_1234, 2, 1'b1, 1'b0); // LHU
      check("lhu", load_data, 32'h00008001);
      txn(1'b1, 1'b0, 2'b00, 1'b1, 32'h3001, 32'h0, 32'h0000_F500, 1, 1'b1, 1'b0); // LBU
      check("lbu", load_data, 32'h000000F5);
      txn(1'b1, 1'b0, 2'b00, 1'b0, 32'h3001, 32'h0, 32'h0000_F500, 1, 1'b1, 1'b0); // LB
      check("lb", load_data, 32'hFFFFFFF5);
      txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h5000, 32'h0, 32'h1234_5678, 2, 1'b1, 1'b1); // ack+err
      check("ackerr_hold", load_data, 32'hFFFFFFF5);
      txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h5004, 32'h0, 32'h1111_2222, 9, 1'b0, 1'b0); // timeout
      txn(1'b1, 1'b0, 2'b10, 1'b0, 32'h5008, 32'h0, 32'hCAFE_F00D, T, 1'b1, 1'b0); // ack on expiry
      txn(1'b1, 1'b1, 2'b10, 1'b0, 32'h4002, 32'h0, 32'h0, 1, 1'b1, 1'b0); // misaligned

      // Async reset in the middle of a transaction
      lsu_valid = 1'b1; load_req = 1'b1; load_size = 2'b10; iadder = 32'h6000;
      @(posedge clk); #1;
      lsu_valid = 1'b0; load_req = 1'b0;
      check("pre_rst_req", 32'(dbus_req), 1);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check("rst_mid_req", 32'(dbus_req), 0);
      check("rst_mid_stall", 32'(lsu_stall), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      exp_load = '0;
      for (int i = 0; i < 3; i++) begin
         check("post_rst_quiet", {29'b0, dbus_req, lsu_done, bus_fault}, 0);
         @(posedge clk); #1;
      end
      check("post_rst_load", load_data, exp_load);

      // Randomized traffic against the reference model
      for (int n = 0; n < 200; n++) begin
         int unsigned r;
         bit ack_r, err_r;
         r = $urandom_range(0, 99);
         ack_r = (r < 80);
         err_r = (r >= 65 && r < 95);
         txn(1'($urandom_range(0, 1)), ($urandom_range(0, 9) == 0), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
             $urandom_range(1, T + 2), ack_r, err_r);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
